// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared opcodes, widths and mode enum for the frog memory controller
package frog_pkg;

    // Default bus widths of the frog CPU
    localparam int FROG_AW = 6;
    localparam int FROG_DW = 4;

    // Opcode constants referenced by the memory controller
    localparam logic [3:0] OP_NGA = 4'h0;
    localparam logic [3:0] OP_NOP = 4'h8;
    localparam logic [3:0] OP_STB = 4'hF;

    // Controller mode: LOAD holds the CPU in reset while the load port fills memory
    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

endpackage

// File: rtl/frog_regfile.sv
// rtl/frog_regfile.sv - DEPTHxDW flop memory, async read port, sync write port
module frog_regfile
    import frog_pkg::*;
#(
    parameter int AW    = FROG_AW,
    parameter int DW    = FROG_DW,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port: contents are deliberately not reset so a reset keeps the program
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is purely combinational so the CPU sees data with zero latency
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/frog_mem_ctrl.sv
// rtl/frog_mem_ctrl.sv - frog CPU program/data memory controller with nibble load port
module frog_mem_ctrl
    import frog_pkg::*;
#(
    parameter int            AW      = FROG_AW,
    parameter int            DW      = FROG_DW,
    parameter int            DEPTH   = 64,
    parameter logic [DW-1:0] NOP_VAL = OP_NOP
) (
    input  logic          clk,
    input  logic          rst_p,
    input  logic [AW-1:0] daout,
    input  logic          wcyc,
    output logic [DW-1:0] data,
    output logic          cpu_rst,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_nibble,
    output logic          ld_ready,
    input  logic          ld_go,
    input  logic          ld_start,
    output logic          werr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    mode_e         mode_q,    mode_d;
    logic [AW-1:0] ld_addr_q, ld_addr_d;
    logic [AW-1:0] waddr_q,   waddr_d;
    logic          wph_q,     wph_d;
    logic          werr_q,    werr_d;
    logic [DW-1:0] hold_q,    hold_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          ld_ready_q, ld_ready_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_data;

    frog_regfile #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (daout),
        .rdata (rd_data)
    );

    // Next-state logic: load sequencing, CPU two-phase write and the shared write-port mux
    always_comb begin
        mode_d    = mode_q;
        ld_addr_d = ld_addr_q;
        waddr_d   = waddr_q;
        wph_d     = wph_q;
        werr_d    = werr_q;
        hold_d    = hold_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr_q;
        mem_wdata = ld_nibble;

        case (mode_q)
            MODE_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    mem_we    = 1'b1;
                    ld_addr_d = ld_addr_q + 1'b1;
                    if (ld_addr_q == LAST_ADDR) begin
                        mode_d = MODE_RUN;
                    end
                end
                // The load write above still lands when ld_go arrives with it
                if (ld_go) begin
                    mode_d = MODE_RUN;
                end
            end
            default: begin
                // The hold register tracks the read value so data stays stable during a write
                if (!wcyc) begin
                    hold_d = rd_data;
                end
                if (ld_start) begin
                    // Re-entering LOAD drops any pending data phase without flagging an error
                    mode_d    = MODE_LOAD;
                    ld_addr_d = '0;
                    wph_d     = 1'b0;
                end else if (wcyc) begin
                    if (!wph_q) begin
                        waddr_d = daout;
                        wph_d   = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = waddr_q;
                        mem_wdata = daout[DW-1:0];
                        wph_d     = 1'b0;
                    end
                end else if (wph_q) begin
                    werr_d = 1'b1;
                    wph_d  = 1'b0;
                end
            end
        endcase

        cpu_rst_d  = (mode_d == MODE_LOAD);
        ld_ready_d = (mode_d == MODE_LOAD);
    end

    // State registers with synchronous active-high reset; outputs are registered from next mode
    always_ff @(posedge clk) begin
        if (rst_p) begin
            mode_q     <= MODE_LOAD;
            ld_addr_q  <= '0;
            waddr_q    <= '0;
            wph_q      <= 1'b0;
            werr_q     <= 1'b0;
            hold_q     <= NOP_VAL;
            cpu_rst_q  <= 1'b1;
            ld_ready_q <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            ld_addr_q  <= ld_addr_d;
            waddr_q    <= waddr_d;
            wph_q      <= wph_d;
            werr_q     <= werr_d;
            hold_q     <= hold_d;
            cpu_rst_q  <= cpu_rst_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    // CPU data mux: NOP while loading, live read when idle, held value during a write
    always_comb begin
        if (mode_q == MODE_RUN) begin
            data = wcyc ? hold_q : rd_data;
        end else begin
            data = NOP_VAL;
        end
    end

    assign cpu_rst  = cpu_rst_q;
    assign ld_ready = ld_ready_q;
    assign werr     = werr_q;

endmodule

// File: tb/tb_frog_mem_ctrl.sv
// tb/tb_frog_mem_ctrl.sv - directed self-checking bench for frog_mem_ctrl
module tb_frog_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [5:0] daout;
    logic       wcyc;
    logic [3:0] data;
    logic       cpu_rst;
    logic       ld_valid;
    logic [3:0] ld_nibble;
    logic       ld_ready;
    logic       ld_go;
    logic       ld_start;
    logic       werr;

    int n_cmp = 0;
    int n_bad = 0;

    frog_mem_ctrl dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .daout     (daout),
        .wcyc      (wcyc),
        .data      (data),
        .cpu_rst   (cpu_rst),
        .ld_valid  (ld_valid),
        .ld_nibble (ld_nibble),
        .ld_ready  (ld_ready),
        .ld_go     (ld_go),
        .ld_start  (ld_start),
        .werr      (werr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [3:0] exp);
        wcyc  = 1'b0;
        daout = a;
        #1;
        chk(tag, {4'h0, data}, {4'h0, exp});
    endtask

    initial begin
        rst_p = 1'b1; daout = '0; wcyc = 1'b0; ld_valid = 1'b0;
        ld_nibble = '0; ld_go = 1'b0; ld_start = 1'b0;
        step(); step();
        rst_p = 1'b0;
        #1;
        chk("rst_cpu_rst",  {7'h0, cpu_rst},  8'h01);
        chk("rst_ld_ready", {7'h0, ld_ready}, 8'h01);
        chk("rst_data",     {4'h0, data},     8'h08);
        chk("rst_werr",     {7'h0, werr},     8'h00);

        // Full load of i[3:0] into all 64 words
        for (int i = 0; i < 64; i++) begin
            ld_valid  = 1'b1;
            ld_nibble = 4'(i);
            daout     = 6'(i);
            step();
            if (i == 62) chk("load_62_still_rst", {7'h0, cpu_rst}, 8'h01);
        end
        ld_valid = 1'b0;
        chk("full_cpu_rst",  {7'h0, cpu_rst},  8'h00);
        chk("full_ld_ready", {7'h0, ld_ready}, 8'h00);
        rd("rd_13", 6'h13, 4'h3);
        rd("rd_2a", 6'h2A, 4'hA);
        rd("rd_3f", 6'h3F, 4'hF);

        // CPU write 0x20 <= 5; data holds mem[0x20]=0 through both write cycles
        rd("pre_wr_20", 6'h20, 4'h0);
        step();
        wcyc = 1'b1; daout = 6'h20; #1;
        chk("wr_addr_hold", {4'h0, data}, 8'h00);
        step();
        daout = 6'h05; #1;
        chk("wr_data_hold", {4'h0, data}, 8'h00);
        step();
        rd("wr_result_20", 6'h20, 4'h5);
        chk("wr_no_werr", {7'h0, werr}, 8'h00);

        // Aborted write to 0x21
        step();
        wcyc = 1'b1; daout = 6'h21;
        step();
        wcyc = 1'b0;
        step();
        chk("abort_werr", {7'h0, werr}, 8'h01);
        rd("abort_21_kept", 6'h21, 4'h1);
        step(); step();
        chk("werr_sticky", {7'h0, werr}, 8'h01);

        // Back-to-back writes 0x30 <= B, 0x31 <= C
        wcyc = 1'b1; daout = 6'h30; step();
        daout = 6'h0B; step();
        daout = 6'h31; step();
        daout = 6'h0C; step();
        rd("b2b_30", 6'h30, 4'hB);
        rd("b2b_31", 6'h31, 4'hC);

        // Reset in RUN: clears werr, returns to LOAD, keeps memory
        rst_p = 1'b1; step(); rst_p = 1'b0; #1;
        chk("rst2_werr",    {7'h0, werr},    8'h00);
        chk("rst2_cpu_rst", {7'h0, cpu_rst}, 8'h01);
        rd("rst2_data_nop", 6'h13, 4'h8);
        ld_go = 1'b1; step(); ld_go = 1'b0;
        chk("go_cpu_rst", {7'h0, cpu_rst}, 8'h00);
        rd("rst2_mem_kept", 6'h13, 4'h3);

        // ld_start during write data phase drops the write
        wcyc = 1'b1; daout = 6'h22; step();
        daout = 6'h07; ld_start = 1'b1; step();
        ld_start = 1'b0; wcyc = 1'b0; #1;
        chk("ldst_cpu_rst",  {7'h0, cpu_rst},  8'h01);
        chk("ldst_ld_ready", {7'h0, ld_ready}, 8'h01);
        chk("ldst_werr",     {7'h0, werr},     8'h00);

        // Early load C,0,D with ld_go alongside the last nibble
        ld_valid = 1'b1; ld_nibble = 4'hC; step();
        ld_nibble = 4'h0; step();
        ld_nibble = 4'hD; ld_go = 1'b1; step();
        ld_valid = 1'b0; ld_go = 1'b0;
        chk("early_cpu_rst", {7'h0, cpu_rst}, 8'h00);
        rd("early_0", 6'h00, 4'hC);
        rd("early_1", 6'h01, 4'h0);
        rd("early_2", 6'h02, 4'hD);
        rd("early_5_prior", 6'h05, 4'h5);
        rd("dropped_22", 6'h22, 4'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
